// File: rtl/mux_demux_4ch.sv
// Registered 4-lane select-and-route: y = lane s of a, g = y placed at lane s, other lanes zero.
// Define MUX_DEMUX_INREG_EN to add an input register stage on a/s (two-cycle latency).
module mux_demux_4ch #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [4*WIDTH-1:0]   a,
  input  logic [1:0]           s,
  output logic [WIDTH-1:0]     y,
  output logic [4*WIDTH-1:0]   g
);

  logic [4*WIDTH-1:0] a_use;
  logic [1:0]         s_use;
  logic [WIDTH-1:0]   m;
  logic [4*WIDTH-1:0] d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [4*WIDTH-1:0] g_q, g_d;

`ifdef MUX_DEMUX_INREG_EN
  logic [4*WIDTH-1:0] a_q, a_d;
  logic [1:0]         s_q, s_d;

  assign a_d = en ? a : a_q;
  assign s_d = en ? s : s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      s_q <= '0;
    end else begin
      a_q <= a_d;
      s_q <= s_d;
    end
  end

  assign a_use = a_q;
  assign s_use = s_q;
`else
  assign a_use = a;
  assign s_use = s;
`endif

  // Mux and demux share one lane decode so only the selected lane is ever driven.
  always_comb begin
    m = '0;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if (s_use == 2'(k)) begin
        m                   = a_use[k*WIDTH +: WIDTH];
        d[k*WIDTH +: WIDTH] = a_use[k*WIDTH +: WIDTH];
      end
    end
  end

  assign y_d = en ? m : y_q;
  assign g_d = en ? d : g_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
      g_q <= '0;
    end else begin
      y_q <= y_d;
      g_q <= g_d;
    end
  end

  assign y = y_q;
  assign g = g_q;

endmodule

// File: tb/tb_mux_demux_4ch.sv
// Scoreboard bench for mux_demux_4ch: WIDTH=1 and WIDTH=8 instances driven in lockstep.
// Expected values come from hand tables (single-stage build) and a cycle model (both builds).
module tb_mux_demux_4ch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [3:0]  a1;
  logic [1:0]  s1;
  logic        y1;
  logic [3:0]  g1;
  logic [31:0] a8;
  logic [1:0]  s8;
  logic [7:0]  y8;
  logic [31:0] g8;

  mux_demux_4ch #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .s(s1), .y(y1), .g(g1)
  );

  mux_demux_4ch #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .s(s8), .y(y8), .g(g8)
  );

`ifdef MUX_DEMUX_INREG_EN
  localparam bit HAND_OK = 1'b0;
`else
  localparam bit HAND_OK = 1'b1;
`endif

  typedef struct {
    logic [7:0]  ey1;
    logic [31:0] eg1;
    logic [7:0]  ey8;
    logic [31:0] eg8;
    bit          hv1;
    logic [7:0]  hy1;
    logic [31:0] hg1;
    bit          hv8;
    logic [7:0]  hy8;
    logic [31:0] hg8;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state, index 0 = WIDTH 1, index 1 = WIDTH 8
  logic [7:0]  my  [2];
  logic [31:0] mg  [2];
  logic [31:0] mar [2];
  logic [1:0]  msr [2];

  function automatic logic [7:0] lane_of(logic [31:0] av, int w, logic [1:0] sv);
    logic [31:0] t;
    t = av >> (int'(sv) * w);
    return 8'(t & ((32'd1 << w) - 32'd1));
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [31:0] av,
                            input logic [1:0] sv, input int i, input int w);
    logic [31:0] sa;
    logic [1:0]  ss;
    if (r) begin
      my[i] = '0; mg[i] = '0; mar[i] = '0; msr[i] = '0;
    end else if (e) begin
`ifdef MUX_DEMUX_INREG_EN
      sa = mar[i]; ss = msr[i];
      mar[i] = av; msr[i] = sv;
`else
      sa = av; ss = sv;
`endif
      my[i] = lane_of(sa, w, ss);
      mg[i] = 32'(my[i]) << (int'(ss) * w);
    end
  endtask

  task automatic step(input bit r, input bit e,
                      input logic [3:0] va1, input logic [1:0] vs1,
                      input logic [31:0] va8, input logic [1:0] vs8,
                      input bit hv1 = 1'b0, input logic [7:0] hy1 = '0, input logic [31:0] hg1 = '0,
                      input bit hv8 = 1'b0, input logic [7:0] hy8 = '0, input logic [31:0] hg8 = '0);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; a1 = va1; s1 = vs1; a8 = va8; s8 = vs8;
    model_edge(r, e, {28'h0, va1}, vs1, 0, 1);
    model_edge(r, e, va8, vs8, 1, 8);
    x.ey1 = my[0]; x.eg1 = mg[0]; x.ey8 = my[1]; x.eg8 = mg[1];
    x.hv1 = hv1 && HAND_OK; x.hy1 = hy1; x.hg1 = hg1;
    x.hv8 = hv8 && HAND_OK; x.hy8 = hy8; x.hg8 = hg8;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output update is compared against the oldest pending expectation.
  initial begin
    exp_t e;
    int   n1, n8;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y_w1_model", {31'h0, y1}, {24'h0, e.ey1});
        chk("g_w1_model", {28'h0, g1}, e.eg1);
        chk("y_w8_model", {24'h0, y8}, {24'h0, e.ey8});
        chk("g_w8_model", g8, e.eg8);
        if (e.hv1) begin
          chk("y_w1_hand", {31'h0, y1}, {24'h0, e.hy1});
          chk("g_w1_hand", {28'h0, g1}, e.hg1);
        end
        if (e.hv8) begin
          chk("y_w8_hand", {24'h0, y8}, {24'h0, e.hy8});
          chk("g_w8_hand", g8, e.hg8);
        end
        n1 = 0; n8 = 0;
        for (int k = 0; k < 4; k++) begin
          if (g1[k] != 1'b0) n1++;
          if (g8[k*8 +: 8] != 8'h0) n8++;
        end
        chk("g_w1_onelane", 32'(n1 <= 1), 32'd1);
        chk("g_w8_onelane", 32'(n8 <= 1), 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; a1 = '0; s1 = '0; a8 = '0; s8 = '0;

    // Reset path
    step(1, 1, 4'b1111, 2'b10, 32'hFFFF_FFFF, 2'b10, 1, 8'h0, 32'h0, 1, 8'h0, 32'h0);
    step(1, 1, 4'b1111, 2'b10, 32'hFFFF_FFFF, 2'b10, 1, 8'h0, 32'h0, 1, 8'h0, 32'h0);
    step(0, 1, 4'b1111, 2'b10, 32'h0, 2'b00, 1, 8'h1, 32'h4, 1, 8'h0, 32'h0);

    // Lane sweep
    step(0, 1, 4'b1010, 2'd0, 32'h0, 2'd0, 1, 8'h0, 32'h0);
    step(0, 1, 4'b1010, 2'd1, 32'h0, 2'd0, 1, 8'h1, 32'h2);
    step(0, 1, 4'b1010, 2'd2, 32'h0, 2'd0, 1, 8'h0, 32'h0);
    step(0, 1, 4'b1010, 2'd3, 32'h0, 2'd0, 1, 8'h1, 32'h8);

    // Multi-bit lanes
    step(0, 1, 4'b0000, 2'd0, 32'hD4C3_B2A1, 2'b11, 1, 8'h0, 32'h0, 1, 8'hD4, 32'hD400_0000);
    step(0, 1, 4'b0000, 2'd0, 32'hD4C3_B2A1, 2'b00, 1, 8'h0, 32'h0, 1, 8'hA1, 32'h0000_00A1);
    step(0, 1, 4'b0000, 2'd0, 32'hD4C3_B2A1, 2'b10, 1, 8'h0, 32'h0, 1, 8'hC3, 32'h00C3_0000);

    // Enable hold
    step(0, 1, 4'b0001, 2'd0, 32'h0, 2'd0, 1, 8'h1, 32'h1);
    step(0, 0, 4'b1110, 2'd1, 32'h1122_3344, 2'd1, 1, 8'h1, 32'h1);
    step(0, 0, 4'b1110, 2'd1, 32'h1122_3344, 2'd1, 1, 8'h1, 32'h1);
    step(0, 0, 4'b1110, 2'd1, 32'h1122_3344, 2'd1, 1, 8'h1, 32'h1);
    step(0, 1, 4'b1110, 2'd1, 32'h1122_3344, 2'd1, 1, 8'h1, 32'h2, 1, 8'h33, 32'h0000_3300);

    // Reset priority mid-stream
    for (int i = 0; i < 6; i++)
      step(0, 1, 4'($urandom), 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
    step(1, 1, 4'hF, 2'd3, 32'hFFFF_FFFF, 2'd3, 1, 8'h0, 32'h0, 1, 8'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 4'($urandom), 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));

    // Random regression
    for (int i = 0; i < 1000; i++)
      step(0, ($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom_range(0, 3)),
           $urandom, 2'($urandom_range(0, 3)));

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
